// File: rtl/button_bank.sv
// Bank of debounced push-button inputs exposed as a bus slave: per-channel
// synchroniser, debounce filter and edge detector, sticky W1C events and a masked irq.
module button_bank #(
    parameter int CHANNELS   = 4,
    parameter int SYNCSTAGES = 2,
    parameter int DEBOUNCE   = 16,
    parameter int ACTIVELOW  = 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [CHANNELS-1:0] keys,
    input  logic [31:0]         busaddr,
    input  logic [31:0]         buswdata,
    input  logic                buswrite,
    output logic [31:0]         busrdata,
    output logic                irq
);

    localparam int          CW       = $clog2(DEBOUNCE + 1);
    localparam logic        POL      = (ACTIVELOW != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [2:0] ADDR_STATE   = 3'd0;
    localparam logic [2:0] ADDR_PRESS   = 3'd1;
    localparam logic [2:0] ADDR_RELEASE = 3'd2;
    localparam logic [2:0] ADDR_IRQEN   = 3'd3;
    localparam logic [2:0] ADDR_RAW     = 3'd4;

    logic [2:0]          reg_sel;
    logic [CHANNELS-1:0] lvl_vec;
    logic [CHANNELS-1:0] state_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;
    logic [CHANNELS-1:0] wdata_ch;

    logic [CHANNELS-1:0] press_q,   press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] irqen_q,   irqen_d;
    logic                irq_q,     irq_d;

    logic                wr_press;
    logic                wr_release;
    logic                wr_irqen;
    logic                unused_bus;

    assign reg_sel  = busaddr[4:2];
    assign wdata_ch = buswdata[CHANNELS-1:0];

    // Address bits outside the register window and data bits above the bank are don't-care.
    assign unused_bus = ^{busaddr[31:5], busaddr[1:0], buswdata};

    // ------------------------------------------------------------------
    // Per-channel synchroniser, debounce filter and edge detector
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNCSTAGES-1:0] sync_q, sync_d;
            logic [CW-1:0]         cnt_q,  cnt_d;
            logic                  state_q, state_d;
            logic                  lvl;

            assign lvl = sync_q[SYNCSTAGES-1] ^ POL;

            // Counter only runs while the synchronised level disagrees with STATE;
            // any agreeing cycle discards the partial count, which rejects short glitches.
            always_comb begin
                sync_d  = {sync_q[SYNCSTAGES-2:0], keys[gi]};
                state_d = state_q;
                cnt_d   = '0;
                if (lvl != state_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = lvl;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    sync_q  <= {SYNCSTAGES{POL}};
                    cnt_q   <= '0;
                    state_q <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                end
            end

            assign lvl_vec[gi]   = lvl;
            assign state_vec[gi] = state_q;
            assign rise_vec[gi]  = state_d & ~state_q;
            assign fall_vec[gi]  = ~state_d & state_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Event, enable and interrupt registers
    // ------------------------------------------------------------------
    always_comb begin
        wr_press   = buswrite && (reg_sel == ADDR_PRESS);
        wr_release = buswrite && (reg_sel == ADDR_RELEASE);
        wr_irqen   = buswrite && (reg_sel == ADDR_IRQEN);

        // A new event on the clearing edge must not be lost, so the set term is OR'd last.
        press_d   = (press_q   & ~(wr_press   ? wdata_ch : '0)) | rise_vec;
        release_d = (release_q & ~(wr_release ? wdata_ch : '0)) | fall_vec;
        irqen_d   = wr_irqen ? wdata_ch : irqen_q;

        irq_d     = |((press_q | release_q) & irqen_q);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            press_q   <= '0;
            release_q <= '0;
            irqen_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            irqen_q   <= irqen_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    // ------------------------------------------------------------------
    // Read mux: current register values, so a same-cycle write reads old data
    // ------------------------------------------------------------------
    always_comb begin
        busrdata = '0;
        case (reg_sel)
            ADDR_STATE:   busrdata = 32'(state_vec);
            ADDR_PRESS:   busrdata = 32'(press_q);
            ADDR_RELEASE: busrdata = 32'(release_q);
            ADDR_IRQEN:   busrdata = 32'(irqen_q);
            ADDR_RAW:     busrdata = 32'(lvl_vec);
            default:      busrdata = '0;
        endcase
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank (4 channels, 2 sync stages, debounce of 4, active-low keys).
module tb_button_bank;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  keys;
    logic [31:0] busaddr;
    logic [31:0] buswdata;
    logic        buswrite;
    logic [31:0] busrdata;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] d;

    localparam logic [2:0] R_STATE = 3'd0, R_PRESS = 3'd1, R_RELEASE = 3'd2,
                           R_IRQEN = 3'd3, R_RAW = 3'd4;

    always #10 clk = ~clk;

    button_bank #(
        .CHANNELS  (4),
        .SYNCSTAGES(2),
        .DEBOUNCE  (4),
        .ACTIVELOW (1)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .keys    (keys),
        .busaddr (busaddr),
        .buswdata(buswdata),
        .buswrite(buswrite),
        .busrdata(busrdata),
        .irq     (irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] v);
        busaddr  = {27'd0, idx, 2'b00};
        buswrite = 1'b0;
        #1;
        v = busrdata;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] v);
        busaddr  = {27'd0, idx, 2'b00};
        buswdata = v;
        buswrite = 1'b1;
        tick(1);
        buswrite = 1'b0;
        buswdata = '0;
    endtask

    task automatic test_reset;
        nrst = 1'b0; keys = 4'hF; buswrite = 1'b0; busaddr = '0; buswdata = '0;
        tick(3);
        nrst = 1'b1;
        tick(1);
        for (int a = 0; a <= 16; a++) begin
            busaddr = a;
            #1;
            checks++;
            if (busrdata !== 32'h0) begin errors++; $display("FAIL reset_read addr=%0d: got %h want %h", a, busrdata, 32'h0); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_clean_press;
        keys[1] = 1'b0;
        tick(1);
        rd(R_RAW, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL raw_after1: got %h want %h", d, 32'h0); end
        tick(1);
        rd(R_RAW, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL raw_after2: got %h want %h", d, 32'h2); end
        tick(3);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL state_after5: got %h want %h", d, 32'h0); end
        tick(1);
        rd(R_STATE, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL state_after6: got %h want %h", d, 32'h2); end
        rd(R_PRESS, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL press_after6: got %h want %h", d, 32'h2); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b want 0", irq); end
        keys[1] = 1'b1;
        tick(5);
        rd(R_STATE, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL rel_state_after5: got %h want %h", d, 32'h2); end
        tick(1);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rel_state_after6: got %h want %h", d, 32'h0); end
        rd(R_RELEASE, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL release_after6: got %h want %h", d, 32'h2); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled_rel: got %b want 0", irq); end
        wr(R_PRESS, 32'h2);
        wr(R_RELEASE, 32'h2);
        rd(R_PRESS, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL press_w1c: got %h want %h", d, 32'h0); end
        rd(R_RELEASE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL release_w1c: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_glitch;
        keys[0] = 1'b0;
        tick(3);
        keys[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            rd(R_STATE, d); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL glitch3_state cyc=%0d: got %h want %h", i, d, 32'h0); end
            rd(R_PRESS, d); checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL glitch3_press cyc=%0d: got %h want %h", i, d, 32'h0); end
        end
        keys[0] = 1'b0;
        tick(4);
        keys[0] = 1'b1;
        tick(1);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL glitch4_state_edge5: got %h want %h", d, 32'h0); end
        tick(1);
        rd(R_STATE, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL glitch4_state_edge6: got %h want %h", d, 32'h1); end
        rd(R_PRESS, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL glitch4_press: got %h want %h", d, 32'h1); end
        tick(6);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL glitch4_settle: got %h want %h", d, 32'h0); end
        rd(R_RELEASE, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL glitch4_release: got %h want %h", d, 32'h1); end
        wr(R_PRESS, 32'h1);
        wr(R_RELEASE, 32'h1);
    endtask

    task automatic test_irq;
        wr(R_IRQEN, 32'h2);
        rd(R_IRQEN, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL irqen_rw: got %h want %h", d, 32'h2); end
        keys[1] = 1'b0;
        tick(6);
        rd(R_PRESS, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL irq_press: got %h want %h", d, 32'h2); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b want 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_raised: got %b want 1", irq); end
        wr(R_PRESS, 32'hFFFF_FFF0);
        rd(R_PRESS, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL w1c_upper_noop: got %h want %h", d, 32'h2); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_noop: got %b want 1", irq); end
        busaddr = {27'd0, R_PRESS, 2'b00}; buswdata = 32'h2; buswrite = 1'b1;
        #1;
        checks++;
        if (busrdata !== 32'h2) begin errors++; $display("FAIL read_during_write: got %h want %h", busrdata, 32'h2); end
        tick(1);
        buswrite = 1'b0; buswdata = '0;
        rd(R_PRESS, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_press_cleared: got %h want %h", d, 32'h0); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag_clear: got %b want 1", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_dropped: got %b want 0", irq); end
        wr(R_IRQEN, 32'h0);
        keys[1] = 1'b1;
        tick(6);
        rd(R_RELEASE, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL irq_release_pending: got %h want %h", d, 32'h2); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", irq); end
        wr(R_IRQEN, 32'h2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_enable_lag: got %b want 0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable_pending: got %b want 1", irq); end
        wr(R_RELEASE, 32'h2);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_release_cleared: got %b want 0", irq); end
        wr(3'd5, 32'hF);
        rd(R_IRQEN, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL unused_write_irqen: got %h want %h", d, 32'h2); end
        rd(3'd5, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unused_read5: got %h want %h", d, 32'h0); end
        rd(3'd7, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unused_read7: got %h want %h", d, 32'h0); end
        wr(R_IRQEN, 32'h0);
    endtask

    task automatic test_collision;
        keys[2] = 1'b0;
        tick(5);
        busaddr = {27'd0, R_PRESS, 2'b00}; buswdata = 32'h4; buswrite = 1'b1;
        tick(1);
        buswrite = 1'b0; buswdata = '0;
        rd(R_PRESS, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL set_wins: got %h want %h", d, 32'h4); end
        rd(R_STATE, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL collide_state: got %h want %h", d, 32'h4); end
        wr(R_PRESS, 32'h4);
        rd(R_PRESS, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL collide_clear: got %h want %h", d, 32'h0); end
        keys[0] = 1'b0; keys[3] = 1'b0;
        tick(6);
        rd(R_PRESS, d); checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL multi_press: got %h want %h", d, 32'h9); end
        rd(R_STATE, d); checks++;
        if (d !== 32'hD) begin errors++; $display("FAIL multi_state: got %h want %h", d, 32'hD); end
        keys = 4'hF;
        tick(6);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL multi_release_state: got %h want %h", d, 32'h0); end
        rd(R_RELEASE, d); checks++;
        if (d !== 32'hD) begin errors++; $display("FAIL multi_release: got %h want %h", d, 32'hD); end
        wr(R_PRESS, 32'hF);
        wr(R_RELEASE, 32'hF);
    endtask

    task automatic test_reset_mid;
        wr(R_IRQEN, 32'hF);
        keys[3] = 1'b0;
        tick(4);
        nrst = 1'b0;
        rd(R_RAW, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL async_raw: got %h want %h", d, 32'h0); end
        rd(R_IRQEN, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL async_irqen: got %h want %h", d, 32'h0); end
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL async_state: got %h want %h", d, 32'h0); end
        tick(2);
        nrst = 1'b1;
        tick(1);
        rd(R_RAW, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_raw1: got %h want %h", d, 32'h0); end
        tick(1);
        rd(R_RAW, d); checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL post_raw2: got %h want %h", d, 32'h8); end
        tick(3);
        rd(R_STATE, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_state5: got %h want %h", d, 32'h0); end
        tick(1);
        rd(R_STATE, d); checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL post_state6: got %h want %h", d, 32'h8); end
        rd(R_PRESS, d); checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL post_press6: got %h want %h", d, 32'h8); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL post_irq: got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_irq();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
